oddr_tx_gearbox: RTL and testbench
==================================

ODDR_TX_GEARBOX -- requirements
Module: oddr_tx_gearbox

Interface
REQ-001 Parameter IDLE_PAT, default 14'h0000: word driven on q when not transmitting data.
REQ-002 Parameter TRAIN_PAT, default 14'h3F80: word driven on q in training mode (7 ones, 7 zeros).
REQ-003 SCLK  input  1  slow (word) clock; all logic on rising edge; same SCLK that feeds the 14:1 serializer.
REQ-004 RSTB  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  enables data transmission.
REQ-006 train_req  input  1  forces training pattern; priority over en.
REQ-007 din  input  16  parallel payload, din[0] oldest bit.
REQ-008 din_valid  input  1  din qualifier.
REQ-009 din_ready  output  1  gearbox accepts din this cycle.
REQ-010 q  output  14  word to serializer D0..D13; q[0] -> D0, transmitted first.
REQ-011 q_data  output  1  high when q carries payload bits.
REQ-012 underrun  output  1  one-cycle pulse: RUN state with fewer than 14 buffered bits.
REQ-013 underrun_cnt  output  8  saturating underrun event count.
REQ-014 cnt_clr  input  1  synchronous clear of underrun_cnt.

Function
REQ-015 States IDLE, TRAIN, RUN held in a registered FSM.
REQ-016 Any state: train_req=1 -> TRAIN next cycle.
REQ-017 IDLE or TRAIN: train_req=0, en=1 -> RUN; train_req=0, en=0 -> IDLE.
REQ-018 RUN: train_req=0, en=0 -> IDLE; otherwise as REQ-016 or stay RUN.
REQ-019 Bit buffer: 32 bits, LSB-oldest, with fill count 0..32 (6-bit).
REQ-020 Leaving RUN (to IDLE or TRAIN) flushes buffer: count <= 0 on that edge; bits discarded.
REQ-021 din_ready = (state==RUN) && (count - (count>=14 ? 14 : 0)) <= 16, from registered state/count only; din_ready never depends on din_valid.
REQ-022 Transfer occurs on edge where din_valid && din_ready; din appended above remaining bits.
REQ-023 RUN, count>=14: q <= buffer[13:0], q_data <= 1, buffer shifts down 14, count -= 14 (plus 16 if transfer).
REQ-024 RUN, count<14: q <= IDLE_PAT, q_data <= 0, underrun <= 1, no partial word emitted, buffered bits retained.
REQ-025 Simultaneous emit and transfer on one edge: emit uses pre-edge buffer; new word lands at post-shift position.
REQ-026 TRAIN: q <= TRAIN_PAT every cycle, q_data <= 0, din_ready=0.
REQ-027 IDLE: q <= IDLE_PAT, q_data <= 0, din_ready=0.
REQ-028 Latency: word accepted at edge k earliest emitted on q after edge k+1.
REQ-029 underrun_cnt increments on each underrun pulse, saturates at 255; cnt_clr wins over increment (result 0).
REQ-030 Output q is registered, one word per SCLK, never stalls; no X on q after reset.

Reset
REQ-031 RSTB=1 at SCLK edge: state IDLE, count 0, buffer 0, q 14'h0000, q_data 0, underrun 0, underrun_cnt 0.
REQ-032 din_ready=0 during and first cycle after reset; RSTB mid-operation discards buffered data, no partial word emitted.
REQ-033 RSTB has priority over train_req, en, cnt_clr.

Verification
REQ-034 Reset, en=1, din_valid=1 with 7 words 16'h0001..16'h0007 streaming -> 8 q words = exact 112-bit concatenation LSB-first, q_data=1, underrun never after first fill.
REQ-035 en=1, single word 16'hFFFF -> one q=14'h3FFF with q_data=1, then underrun pulses each cycle, underrun_cnt increments, 2 bits retained.
REQ-036 train_req=1 in RUN with count=10 -> next q=14'h3F80 repeatedly, din_ready=0; release with en=1 -> RUN with count 0.
REQ-037 din_valid held 1 continuously -> din_ready duty 7/8, count never exceeds 32, no data lost or duplicated.
REQ-038 Force 300 underruns -> underrun_cnt=255; cnt_clr with concurrent underrun -> 0.
REQ-039 RSTB asserted mid-stream -> all outputs reset values next cycle; restart streams from fresh alignment.

Source files
------------

// File: rtl/oddr_tx_gearbox.sv
// 16-bit payload to 14-bit word gearbox ahead of a 14:1 ODDR serializer (IDLE/TRAIN/RUN).
// Latency: word accepted at edge k is earliest on q after edge k+1; q never stalls; din_ready throttles input.
module oddr_tx_gearbox #(
  parameter logic [13:0] IDLE_PAT  = 14'h0000,
  parameter logic [13:0] TRAIN_PAT = 14'h3F80
) (
  input  logic        SCLK,
  input  logic        RSTB,
  input  logic        en,
  input  logic        train_req,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [13:0] q,
  output logic        q_data,
  output logic        underrun,
  output logic [7:0]  underrun_cnt,
  input  logic        cnt_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] bit_buf;
  logic [31:0] bit_buf_nxt;
  logic [5:0]  count;
  logic [5:0]  count_nxt;
  logic [13:0] q_nxt;
  logic        q_data_nxt;
  logic        underrun_nxt;
  logic [7:0]  underrun_cnt_nxt;

  logic        emit;
  logic        xfer;
  logic [5:0]  rem_cnt;
  logic [31:0] rem_buf;
  logic [31:0] din_shifted;

  // Bits left after this edge's emit; a new word is placed right above them.
  assign emit        = (state == ST_RUN) && (count >= 6'd14);
  assign rem_cnt     = emit ? (count - 6'd14) : count;
  assign rem_buf     = emit ? {14'b0, bit_buf[31:14]} : bit_buf;
  assign din_shifted = {16'b0, din} << rem_cnt;

  assign din_ready   = (state == ST_RUN) && (rem_cnt <= 6'd16);
  assign xfer        = din_valid && din_ready;

  always_comb begin
    state_nxt        = ST_IDLE;
    bit_buf_nxt      = rem_buf;
    count_nxt        = rem_cnt;
    q_nxt            = IDLE_PAT;
    q_data_nxt       = 1'b0;
    underrun_nxt     = 1'b0;
    underrun_cnt_nxt = underrun_cnt;

    if (train_req) begin
      state_nxt = ST_TRAIN;
    end else if (en) begin
      state_nxt = ST_RUN;
    end else begin
      state_nxt = ST_IDLE;
    end

    case (state)
      ST_RUN: begin
        if (emit) begin
          q_nxt      = bit_buf[13:0];
          q_data_nxt = 1'b1;
        end else begin
          underrun_nxt = 1'b1;
        end
        if (xfer) begin
          bit_buf_nxt = rem_buf | din_shifted;
          count_nxt   = rem_cnt + 6'd16;
        end
      end
      ST_TRAIN: begin
        q_nxt = TRAIN_PAT;
      end
      default: begin
        q_nxt = IDLE_PAT;
      end
    endcase

    // Leaving RUN drops whatever is buffered so a restart begins word-aligned.
    if (state_nxt != ST_RUN) begin
      bit_buf_nxt = 32'b0;
      count_nxt   = 6'd0;
    end

    if (cnt_clr) begin
      underrun_cnt_nxt = 8'd0;
    end else if (underrun_nxt && (underrun_cnt != 8'hFF)) begin
      underrun_cnt_nxt = underrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge SCLK) begin
    if (RSTB) begin
      state        <= ST_IDLE;
      bit_buf      <= 32'b0;
      count        <= 6'd0;
      q            <= 14'h0000;
      q_data       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      state        <= state_nxt;
      bit_buf      <= bit_buf_nxt;
      count        <= count_nxt;
      q            <= q_nxt;
      q_data       <= q_data_nxt;
      underrun     <= underrun_nxt;
      underrun_cnt <= underrun_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_oddr_tx_gearbox.sv
// Directed bench for oddr_tx_gearbox: streaming alignment, underrun, training, counter saturation, reset.
module tb_oddr_tx_gearbox;

  logic        SCLK = 1'b0;
  logic        RSTB;
  logic        en;
  logic        train_req;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [13:0] q;
  logic        q_data;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic        cnt_clr;

  int checks = 0;
  int failures = 0;

  oddr_tx_gearbox dut (
    .SCLK(SCLK), .RSTB(RSTB), .en(en), .train_req(train_req),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .q(q), .q_data(q_data), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .cnt_clr(cnt_clr)
  );

  always #5 SCLK = ~SCLK;

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Words 1..7 concatenated LSB-first, cut into 14-bit slices.
  logic [13:0] exp_w [8] = '{14'h0001, 14'h0008, 14'h0030, 14'h0100,
                             14'h0500, 14'h1800, 14'h3000, 14'h0001};

  logic        bq [$];
  logic [13:0] w;
  logic        acc;
  int          rdy_cnt;

  initial begin
    RSTB = 1'b1; en = 1'b0; train_req = 1'b0; din = 16'h0;
    din_valid = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_q_data", 32'(q_data), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_cnt", 32'(underrun_cnt), 32'h0);
    chk("rst_ready", 32'(din_ready), 32'h0);

    // Aligned stream of seven words
    RSTB = 1'b0; en = 1'b1;
    chk("ready_after_rst", 32'(din_ready), 32'h0);
    tick();
    for (int i = 1; i <= 7; i++) begin
      din = 16'(i); din_valid = 1'b1;
      chk("stream_ready", 32'(din_ready), 32'h1);
      tick();
      if (i == 1) begin
        chk("first_underrun", 32'(underrun), 32'h1);
      end else begin
        chk("stream_q", 32'(q), 32'(exp_w[i-2]));
        chk("stream_q_data", 32'(q_data), 32'h1);
        chk("stream_no_underrun", 32'(underrun), 32'h0);
      end
    end
    din_valid = 1'b0;
    tick();
    chk("stream_q6", 32'(q), 32'(exp_w[6]));
    tick();
    chk("stream_q7", 32'(q), 32'(exp_w[7]));
    chk("stream_q7_data", 32'(q_data), 32'h1);
    tick();
    chk("drain_underrun", 32'(underrun), 32'h1);
    chk("drain_q_data", 32'(q_data), 32'h0);
    chk("drain_cnt", 32'(underrun_cnt), 32'd2);

    // Single 0xFFFF word, then starvation
    RSTB = 1'b1; tick();
    chk("rst2_cnt", 32'(underrun_cnt), 32'h0);
    chk("rst2_q_data", 32'(q_data), 32'h0);
    RSTB = 1'b0; tick();
    din = 16'hFFFF; din_valid = 1'b1;
    tick();
    chk("ffff_underrun", 32'(underrun), 32'h1);
    chk("ffff_cnt1", 32'(underrun_cnt), 32'd1);
    din_valid = 1'b0;
    tick();
    chk("ffff_q", 32'(q), 32'h3FFF);
    chk("ffff_q_data", 32'(q_data), 32'h1);
    chk("ffff_no_underrun", 32'(underrun), 32'h0);
    tick();
    chk("starve_underrun", 32'(underrun), 32'h1);
    chk("starve_q", 32'(q), 32'h0);
    chk("starve_cnt2", 32'(underrun_cnt), 32'd2);
    tick();
    chk("starve_cnt3", 32'(underrun_cnt), 32'd3);
    din = 16'h0000; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    chk("retained_bits_q", 32'(q), 32'h0003);
    chk("retained_bits_data", 32'(q_data), 32'h1);

    // Build count up to 10, then training
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1; tick();
      din_valid = 1'b0; tick();
    end
    train_req = 1'b1;
    tick();
    chk("train_enter_underrun", 32'(underrun), 32'h1);
    chk("train_ready", 32'(din_ready), 32'h0);
    tick();
    chk("train_q1", 32'(q), 32'h3F80);
    chk("train_q_data", 32'(q_data), 32'h0);
    tick();
    chk("train_q2", 32'(q), 32'h3F80);
    chk("train_ready2", 32'(din_ready), 32'h0);
    train_req = 1'b0;
    tick();
    chk("train_exit_q", 32'(q), 32'h3F80);
    chk("run_ready", 32'(din_ready), 32'h1);
    din = 16'h1234; din_valid = 1'b1;
    tick();
    chk("flushed_underrun", 32'(underrun), 32'h1);
    din_valid = 1'b0;
    tick();
    chk("flushed_q", 32'(q), 32'h1234);
    chk("flushed_q_data", 32'(q_data), 32'h1);

    // Counter clear and saturation
    cnt_clr = 1'b1; tick();
    chk("clr_underrun", 32'(underrun), 32'h1);
    chk("clr_cnt", 32'(underrun_cnt), 32'h0);
    cnt_clr = 1'b0;
    repeat (254) tick();
    chk("cnt_254", 32'(underrun_cnt), 32'd254);
    tick();
    chk("cnt_255", 32'(underrun_cnt), 32'd255);
    repeat (46) tick();
    chk("cnt_sat", 32'(underrun_cnt), 32'd255);
    cnt_clr = 1'b1; tick();
    chk("clr2_underrun", 32'(underrun), 32'h1);
    chk("clr2_cnt", 32'(underrun_cnt), 32'h0);
    cnt_clr = 1'b0;

    // Continuous valid: duty and bit-exact scoreboard
    RSTB = 1'b1; tick();
    RSTB = 1'b0; tick();
    din = 16'h1357; din_valid = 1'b1; rdy_cnt = 0;
    for (int c = 0; c < 72; c++) begin
      acc = din_ready && din_valid;
      if (c >= 2 && c < 66 && din_ready) rdy_cnt++;
      if (acc) for (int b = 0; b < 16; b++) bq.push_back(din[b]);
      tick();
      if (acc) din = din + 16'h1357;
      if (q_data) begin
        if (bq.size() < 14) begin
          chk("sb_underflow", 32'(bq.size()), 32'd14);
        end else begin
          for (int b = 0; b < 14; b++) w[b] = bq.pop_front();
          chk("sb_word", 32'(q), 32'(w));
        end
      end
    end
    chk("ready_duty", 32'(rdy_cnt), 32'd56);

    // Reset mid-stream, restart aligned
    RSTB = 1'b1; tick();
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_q_data", 32'(q_data), 32'h0);
    chk("mid_rst_underrun", 32'(underrun), 32'h0);
    chk("mid_rst_cnt", 32'(underrun_cnt), 32'h0);
    chk("mid_rst_ready", 32'(din_ready), 32'h0);
    RSTB = 1'b0;
    chk("mid_rst_ready_after", 32'(din_ready), 32'h0);
    din = 16'h2AAA;
    tick();
    tick();
    din_valid = 1'b0;
    tick();
    chk("restart_q", 32'(q), 32'h2AAA);
    chk("restart_q_data", 32'(q_data), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
